// File: rtl/nios_multi_timer.sv
// nios_multi_timer: multi-channel interval timer, Avalon-MM slave.
// Per channel: prescaled down-counter, one-shot/continuous, snapshot, irq.
module nios_multi_timer #(
    parameter int              NUM_CH     = 4,
    parameter int              CNT_W      = 32,
    parameter logic [CNT_W-1:0] PERIOD_RST = {CNT_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [$clog2(NUM_CH)+1:0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq,
    output logic [NUM_CH-1:0]         irq_vec,
    output logic [NUM_CH-1:0]         pulse_out
);

    localparam int AW = $clog2(NUM_CH) + 2;
    localparam int IW = (AW > 2) ? AW - 2 : 1;

    logic              wr;
    logic [IW-1:0]     ch_idx;
    logic [1:0]        reg_sel;
    logic [31:0]       rdw [NUM_CH];
    logic [31:0]       rd_d;
    logic [31:0]       rd_q;
    logic [NUM_CH-1:0] ivec;
    logic [NUM_CH-1:0] pls;
    logic              unused_wd;

    assign wr        = chipselect & ~write_n;
    assign reg_sel   = address[1:0];
    assign unused_wd = ^writedata;

    if (AW > 2) begin : g_idx
        assign ch_idx = address[AW-1:2];
    end else begin : g_idx0
        assign ch_idx = '0;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             sel;
        logic             wr_st;
        logic             wr_ct;
        logic             wr_pd;
        logic             wr_sn;
        logic             start;
        logic             stop;
        logic             tick;
        logic             evt;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] per_q, per_d;
        logic [CNT_W-1:0] snap_q, snap_d;
        logic             run_q, run_d;
        logic             to_q, to_d;
        logic             ito_q, ito_d;
        logic             cont_q, cont_d;
        logic             pls_q, pls_d;
        logic [7:0]       presc_q, presc_d;
        logic [7:0]       pcnt_q, pcnt_d;
        logic [31:0]      rdw_l;

        assign sel   = wr & (ch_idx == IW'(g));
        assign wr_st = sel & (reg_sel == 2'd0);
        assign wr_ct = sel & (reg_sel == 2'd1);
        assign wr_pd = sel & (reg_sel == 2'd2);
        assign wr_sn = sel & (reg_sel == 2'd3);
        assign start = wr_ct & writedata[2];
        assign stop  = wr_ct & writedata[3];
        assign tick  = run_q & (pcnt_q == presc_q);
        // Timeout only when no higher-priority register action this clk
        assign evt   = tick & (cnt_q == '0) & ~wr_pd & ~start & ~stop;

        // Next-state: prescaler, control fields, counter priority chain
        always_comb begin
            cnt_d   = cnt_q;
            per_d   = per_q;
            snap_d  = snap_q;
            run_d   = run_q;
            ito_d   = ito_q;
            cont_d  = cont_q;
            presc_d = presc_q;
            pcnt_d  = pcnt_q;
            pls_d   = evt;
            to_d    = to_q;

            if (run_q) begin
                pcnt_d = tick ? 8'd0 : 8'(pcnt_q + 8'd1);
            end

            if (wr_ct) begin
                ito_d   = writedata[0];
                cont_d  = writedata[1];
                presc_d = writedata[15:8];
            end

            if (wr_sn) begin
                snap_d = cnt_q;
            end

            if (wr_pd) begin
                per_d  = writedata[CNT_W-1:0];
                cnt_d  = writedata[CNT_W-1:0];
                run_d  = 1'b0;
                pcnt_d = 8'd0;
            end else if (start) begin
                run_d  = 1'b1;
                pcnt_d = 8'd0;
            end else if (stop) begin
                run_d  = 1'b0;
            end else if (evt) begin
                cnt_d = per_q;
                if (!cont_q) begin
                    run_d = 1'b0;
                end
            end else if (tick) begin
                cnt_d = cnt_q - CNT_W'(1);
            end

            // A timeout beats a simultaneous clear so no event is lost
            if (evt) begin
                to_d = 1'b1;
            end else if (wr_st) begin
                to_d = 1'b0;
            end
        end

        // Channel state registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q   <= PERIOD_RST;
                per_q   <= PERIOD_RST;
                snap_q  <= '0;
                run_q   <= 1'b0;
                to_q    <= 1'b0;
                ito_q   <= 1'b0;
                cont_q  <= 1'b0;
                presc_q <= 8'd0;
                pcnt_q  <= 8'd0;
                pls_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                per_q   <= per_d;
                snap_q  <= snap_d;
                run_q   <= run_d;
                to_q    <= to_d;
                ito_q   <= ito_d;
                cont_q  <= cont_d;
                presc_q <= presc_d;
                pcnt_q  <= pcnt_d;
                pls_q   <= pls_d;
            end
        end

        // Register read word for this channel
        always_comb begin
            rdw_l = '0;
            unique case (reg_sel)
                2'd0:    rdw_l = {30'd0, run_q, to_q};
                2'd1:    rdw_l = {16'd0, presc_q, 6'd0, cont_q, ito_q};
                2'd2:    rdw_l = 32'(per_q);
                default: rdw_l = 32'(snap_q);
            endcase
        end

        assign rdw[g]  = rdw_l;
        assign ivec[g] = to_q & ito_q;
        assign pls[g]  = pls_q;
    end

    // Channel read mux; an unmatched index yields zero
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == IW'(i)) begin
                rd_d = rdw[i];
            end
        end
    end

    // Registered read data, refreshed every clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign readdata  = rd_q;
    assign irq_vec   = ivec;
    assign irq       = |ivec;
    assign pulse_out = pls;

endmodule

// File: tb/tb_nios_multi_timer.sv
// tb_nios_multi_timer: self-checking bench for nios_multi_timer.
// Two instances: default 4x32, and 3 channels x 16 bits for range checks.
module tb_nios_multi_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;
    logic [3:0]  pulse_out;
    logic [31:0] readdata_b;
    logic        irq_b;
    logic [2:0]  irq_vec_b;
    logic [2:0]  pulse_out_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        w;
        logic        b;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    nios_multi_timer u_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec),
        .pulse_out  (pulse_out)
    );

    nios_multi_timer #(.NUM_CH(3), .CNT_W(16)) u_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_b),
        .irq        (irq_b),
        .irq_vec    (irq_vec_b),
        .pulse_out  (pulse_out_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus write, started and finished on a negedge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // One read: expectation queued, compared when readdata lands
    task automatic rd(input string name, input logic b,
                      input logic [3:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        address = a;
        @(negedge clk);
        check(name, b ? readdata_b : readdata, exp_q.pop_front());
    endtask

    initial begin
        int hits;
        int first;

        tbl[0]  = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b0, 4'h1, 32'h0, 32'h0000_0000};
        tbl[2]  = '{1'b0, 1'b0, 4'h2, 32'h0, 32'hFFFF_FFFF};
        tbl[3]  = '{1'b0, 1'b0, 4'h3, 32'h0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 1'b0, 4'hE, 32'h0, 32'hFFFF_FFFF};
        tbl[5]  = '{1'b0, 1'b1, 4'h2, 32'h0, 32'h0000_FFFF};
        tbl[6]  = '{1'b0, 1'b1, 4'hE, 32'h0, 32'h0000_0000};
        tbl[7]  = '{1'b1, 1'b0, 4'h2, 32'hABCD_EF01, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 4'h2, 32'h0, 32'h0000_EF01};
        tbl[9]  = '{1'b0, 1'b0, 4'h2, 32'h0, 32'hABCD_EF01};
        tbl[10] = '{1'b1, 1'b0, 4'hD, 32'h0000_AB13, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 4'hD, 32'h0, 32'h0000_AB03};
        tbl[12] = '{1'b0, 1'b1, 4'hD, 32'h0, 32'h0000_0000};
        tbl[13] = '{1'b1, 1'b0, 4'hD, 32'h0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 4'hC, 32'h0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_irq_vec", 32'(irq_vec), 32'h0);
        check("rst_pulse", 32'(pulse_out), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].w) begin
                wr(tbl[i].a, tbl[i].d);
            end else begin
                rd($sformatf("vec%0d", i), tbl[i].b, tbl[i].a, tbl[i].e);
            end
        end

        // ch1 continuous, PERIOD=4, PRESC=0: timeout every 5 clks
        wr(4'h6, 32'd4);
        wr(4'h5, 32'h0000_0007);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check($sformatf("ch1_pulse_%0d", k), 32'(pulse_out[1]),
                  32'((k % 5) == 0));
        end
        check("ch1_irq_vec", 32'(irq_vec), 32'h2);
        check("ch1_irq", 32'(irq), 32'h1);
        rd("ch1_status_to", 1'b0, 4'h4, 32'h3);
        wr(4'h4, 32'h0);
        rd("ch1_status_clr", 1'b0, 4'h4, 32'h2);
        @(negedge clk);
        check("ch1_irq_low", 32'(irq), 32'h0);
        @(negedge clk);
        check("ch1_irq_again", 32'(irq), 32'h1);
        repeat (4) @(negedge clk);
        wr(4'h4, 32'h0);
        check("ch1_to_kept", 32'(irq_vec[1]), 32'h1);
        check("ch1_pulse_coinc", 32'(pulse_out[1]), 32'h1);
        wr(4'h5, 32'h0000_0008);
        wr(4'h4, 32'h0);
        check("ch1_quiet", 32'(irq_vec), 32'h0);

        // ch0 one-shot, PERIOD=9, PRESC=3: one timeout 40 clks after start
        wr(4'h2, 32'd9);
        wr(4'h1, 32'h0000_0305);
        hits  = 0;
        first = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (pulse_out[0]) begin
                hits++;
                if (first < 0) first = k;
            end
        end
        check("ch0_hits", 32'(hits), 32'd1);
        check("ch0_when", 32'(first), 32'd40);
        check("ch0_irq_vec", 32'(irq_vec), 32'h1);
        rd("ch0_status", 1'b0, 4'h0, 32'h1);
        wr(4'h3, 32'h0);
        rd("ch0_reload", 1'b0, 4'h3, 32'd9);
        wr(4'h0, 32'h0);
        wr(4'h1, 32'h0);

        // ch2 snapshot while running, then PERIOD write mid-count
        wr(4'hA, 32'h0000_1240);
        wr(4'h9, 32'h0000_0004);
        repeat (12) @(negedge clk);
        wr(4'hB, 32'hDEAD_BEEF);
        rd("ch2_snap1", 1'b0, 4'hB, 32'h0000_1234);
        wr(4'hB, 32'h0);
        rd("ch2_snap2", 1'b0, 4'hB, 32'h0000_1232);
        wr(4'hA, 32'h0000_0055);
        rd("ch2_stopped", 1'b0, 4'h8, 32'h0);
        wr(4'hB, 32'h0);
        rd("ch2_newcnt", 1'b0, 4'hB, 32'h0000_0055);

        // START and STOP together: START wins
        wr(4'h9, 32'h0000_000C);
        rd("ch2_startstop", 1'b0, 4'h8, 32'h2);
        rd("ch2_ctl_wo", 1'b0, 4'h9, 32'h0);
        wr(4'h9, 32'h0000_0008);
        rd("ch2_stop", 1'b0, 4'h8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
